// File: rtl/div_pkg.sv
// Shared constants for the 32-bit non-restoring divider sequencer.
//   WIDTH  : operand width (result is 2*WIDTH)
//   ITERS  : number of shift/add-subtract iterations
//   CNT_W  : iteration counter width
//   S_*    : sequencer state encodings
//   abs_val: two's-complement magnitude, applied only when en=1
package div_pkg;

   localparam int WIDTH = 32;
   localparam int ITERS = WIDTH;
   localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PREP  = 3'd1;
   localparam logic [2:0] S_ITER  = 3'd2;
   localparam logic [2:0] S_FIXUP = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Result is taken as unsigned, so |-2^(W-1)| comes out exact.
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                input logic             en);
      return (en && v[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational non-restoring division step.
//   a_i [W:0]   partial remainder (sign in bit W)
//   q_i [W-1:0] quotient/dividend shift register
//   m_i [W-1:0] divisor magnitude
//   a_o, q_o    values after shifting {A,Q} left and add/subtracting M
module div_step
   import div_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic [W:0]   a_i,
   input  logic [W-1:0] q_i,
   input  logic [W-1:0] m_i,
   output logic [W:0]   a_o,
   output logic [W-1:0] q_o
);

   logic [W:0] a_sh;

   always_comb begin
      a_sh = {a_i[W-1:0], q_i[W-1]};
      // Direction depends on the sign of A before the shift.
      a_o  = a_i[W] ? (a_sh + {1'b0, m_i}) : (a_sh - {1'b0, m_i});
      q_o  = {q_i[W-2:0], ~a_o[W]};
   end

endmodule

// File: rtl/div_32_ctrl.sv
// Multi-cycle sequencer for a 32-bit non-restoring divider.
//   clock     : rising-edge clock
//   clear_n   : synchronous active-low reset
//   start     : request, sampled only while idle
//   signed_op : 1 = two's-complement, 0 = unsigned
//   a_in/b_in : dividend / divisor, latched on accept
//   busy      : high whenever the sequencer is not idle
//   done      : one-cycle completion pulse
//   dbz       : divide-by-zero flag, held until next accept
//   z_out     : {remainder, quotient}, held until next completion
module div_32_ctrl
   import div_pkg::*;
#(
   parameter int WIDTH = div_pkg::WIDTH,
   parameter int ITERS = WIDTH
) (
   input  logic               clock,
   input  logic               clear_n,
   input  logic               start,
   input  logic               signed_op,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic               busy,
   output logic               done,
   output logic               dbz,
   output logic [2*WIDTH-1:0] z_out
);

   localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

   logic [2:0]         state_q, state_d;
   logic [WIDTH-1:0]   ain_q, ain_d, bin_q, bin_d;
   logic               sgn_q, sgn_d;
   logic [WIDTH:0]     acc_q, acc_d;
   logic [WIDTH-1:0]   quo_q, quo_d, m_q, m_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               negq_q, negq_d, negr_q, negr_d;
   logic               dbz_q, dbz_d;
   logic [2*WIDTH-1:0] z_q, z_d;

   logic [WIDTH:0]     step_a;
   logic [WIDTH-1:0]   step_q;
   logic [WIDTH-1:0]   rem;

   div_step #(.W(WIDTH)) u_step (
      .a_i (acc_q),
      .q_i (quo_q),
      .m_i (m_q),
      .a_o (step_a),
      .q_o (step_q)
   );

   always_comb begin
      state_d = state_q;
      ain_d   = ain_q;
      bin_d   = bin_q;
      sgn_d   = sgn_q;
      acc_d   = acc_q;
      quo_d   = quo_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      dbz_d   = dbz_q;
      z_d     = z_q;
      // Restore a negative final remainder by adding M back.
      rem     = acc_q[WIDTH] ? (acc_q[WIDTH-1:0] + m_q) : acc_q[WIDTH-1:0];
      case (state_q)
         S_IDLE: if (start) begin
            ain_d   = a_in;
            bin_d   = b_in;
            sgn_d   = signed_op;
            dbz_d   = 1'b0;
            state_d = S_PREP;
         end
         S_PREP: if (bin_q == '0) begin
            // Raw latched dividend goes out as the remainder.
            z_d     = {ain_q, {WIDTH{1'b1}}};
            dbz_d   = 1'b1;
            state_d = S_DONE;
         end else begin
            negq_d  = sgn_q & (ain_q[WIDTH-1] ^ bin_q[WIDTH-1]);
            negr_d  = sgn_q & ain_q[WIDTH-1];
            acc_d   = '0;
            quo_d   = abs_val(ain_q, sgn_q);
            m_d     = abs_val(bin_q, sgn_q);
            cnt_d   = '0;
            state_d = S_ITER;
         end
         S_ITER: begin
            acc_d = step_a;
            quo_d = step_q;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(ITERS - 1)) state_d = S_FIXUP;
         end
         S_FIXUP: begin
            z_d     = {negr_q ? (~rem + 1'b1) : rem,
                       negq_q ? (~quo_q + 1'b1) : quo_q};
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!clear_n) begin
         state_q <= S_IDLE;
         ain_q   <= '0;
         bin_q   <= '0;
         sgn_q   <= 1'b0;
         acc_q   <= '0;
         quo_q   <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dbz_q   <= 1'b0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         ain_q   <= ain_d;
         bin_q   <= bin_d;
         sgn_q   <= sgn_d;
         acc_q   <= acc_d;
         quo_q   <= quo_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dbz_q   <= dbz_d;
         z_q     <= z_d;
      end
   end

   assign busy  = (state_q != S_IDLE);
   assign done  = (state_q == S_DONE);
   assign dbz   = dbz_q;
   assign z_out = z_q;

endmodule

// File: tb/tb_div_32_ctrl.sv
// Directed bench for div_32_ctrl. Latency is counted in rising edges after
// the accepting edge: done must be visible after edge +34 (normal) or +1
// (divide by zero); busy is sampled once after each of those edges.
module tb_div_32_ctrl;

   logic        clock = 1'b0;
   logic        clear_n, start, signed_op;
   logic [31:0] a_in, b_in;
   logic        busy, done, dbz;
   logic [63:0] z_out;

   int n_chk = 0;
   int n_err = 0;

   div_32_ctrl dut (
      .clock     (clock),
      .clear_n   (clear_n),
      .start     (start),
      .signed_op (signed_op),
      .a_in      (a_in),
      .b_in      (b_in),
      .busy      (busy),
      .done      (done),
      .dbz       (dbz),
      .z_out     (z_out)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one operation and watch it to completion. restart_at >= 0 pulses
   // start again (with other operands) at that sample index.
   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input int restart_at,
                      input logic [63:0] exp_z, input logic exp_dbz, input int exp_lat);
      int lat, bcnt, ndone;
      lat = -1; bcnt = 0; ndone = 0;
      @(negedge clock);
      a_in = a; b_in = b; signed_op = s; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; a_in = $urandom; b_in = $urandom; signed_op = ~s;
      for (int i = 0; i < 100; i++) begin
         if (busy) bcnt++;
         if (done) begin
            ndone++;
            if (lat < 0) lat = i;
         end
         if (!busy) break;
         if (i == restart_at) begin
            a_in = 32'd9; b_in = 32'd3; start = 1'b1;
         end else start = 1'b0;
         @(posedge clock); #1;
      end
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         if (done) ndone++;
      end
      chk({tag, ".lat"},   64'(lat),   64'(exp_lat));
      chk({tag, ".busy"},  64'(bcnt),  64'(exp_lat + 1));
      chk({tag, ".ndone"}, 64'(ndone), 64'd1);
      chk({tag, ".z"},     z_out,      exp_z);
      chk({tag, ".dbz"},   64'(dbz),   64'(exp_dbz));
   endtask

   initial begin
      clear_n = 1'b0; start = 1'b0; signed_op = 1'b0; a_in = '0; b_in = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.done", 64'(done), 64'd0);
      chk("rst.dbz",  64'(dbz),  64'd0);
      chk("rst.z",    z_out,     64'd0);
      clear_n = 1'b1;

      run("u100_7",   32'd100,        32'd7,          1'b0, -1, 64'h00000002_0000000E, 1'b0, 34);
      run("s-100_7",  32'hFFFFFF9C,   32'd7,          1'b1, -1, 64'hFFFFFFFE_FFFFFFF2, 1'b0, 34);
      run("s100_-7",  32'd100,        32'hFFFFFFF9,   1'b1, -1, 64'h00000002_FFFFFFF2, 1'b0, 34);
      run("s-100_-7", 32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, -1, 64'hFFFFFFFE_0000000E, 1'b0, 34);
      run("u9C_7",    32'hFFFFFF9C,   32'd7,          1'b0, -1, 64'h00000002_24924916, 1'b0, 34);
      run("u5_0",     32'd5,          32'd0,          1'b0, -1, 64'h00000005_FFFFFFFF, 1'b1, 1);
      run("u9_3",     32'd9,          32'd3,          1'b0, -1, 64'h00000000_00000003, 1'b0, 34);
      run("s5_0",     32'd5,          32'd0,          1'b1, -1, 64'h00000005_FFFFFFFF, 1'b1, 1);
      run("s-5_0",    32'hFFFFFFFB,   32'd0,          1'b1, -1, 64'hFFFFFFFB_FFFFFFFF, 1'b1, 1);
      run("smin_-1",  32'h80000000,   32'hFFFFFFFF,   1'b1, -1, 64'h00000000_80000000, 1'b0, 34);
      run("umax_1",   32'hFFFFFFFF,   32'd1,          1'b0, -1, 64'h00000000_FFFFFFFF, 1'b0, 34);
      run("restart",  32'd100,        32'd7,          1'b0, 10, 64'h00000002_0000000E, 1'b0, 34);

      // Reset partway through the iterations discards the operation.
      @(negedge clock);
      a_in = 32'd1000; b_in = 32'd3; signed_op = 1'b0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (17) @(posedge clock);
      #1;
      chk("mid.busy_pre", 64'(busy), 64'd1);
      clear_n = 1'b0;
      @(posedge clock); #1;
      clear_n = 1'b1;
      chk("mid.busy", 64'(busy), 64'd0);
      chk("mid.done", 64'(done), 64'd0);
      chk("mid.z",    z_out,     64'd0);
      run("after_rst", 32'd1000, 32'd3, 1'b0, -1, 64'h00000001_0000014D, 1'b0, 34);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
